// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - parametrised SPI master: four CPOL/CPHA modes, MSB/LSB order, one-hot slave selects
module spi_master_gen #(
    parameter int  DATA_W  = 8,
    parameter int  NUM_SS  = 4,
    parameter int  CLK_DIV = 2,
    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sel_err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [SS_W:0]     SS_LIMIT  = (SS_W + 1)'(NUM_SS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_q;
    logic [SS_W-1:0]   sel_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              sclk_q;
    logic              mosi_q;

    logic              accept;
    logic              div_last;
    logic              sclk_edge;
    logic              leading;
    logic              final_edge;
    logic              shift_evt;
    logic              sample_evt;
    logic              in_range;
    logic              tx_first;
    logic [DATA_W-1:0] tx_shifted;
    logic              in_first;
    logic [DATA_W-1:0] in_shifted;

    // A start is only honoured while idle; everything else about it is ignored.
    assign accept   = (state == S_IDLE) && start;
    assign div_last = (div_cnt == DIV_LAST);

    // One SCLK edge per divider expiry, only while shifting. edge_cnt holds
    // the number of edges already made, so an even count means the upcoming
    // edge is a leading one.
    assign sclk_edge  = (state == S_XFER) && div_last;
    assign leading    = ~edge_cnt[0];
    assign final_edge = (edge_cnt == EDGE_LAST);

    // CPHA=0 presents the first bit before any edge, so trailing edges only
    // advance to the next bit (none after the last). CPHA=1 launches every
    // bit, including the first, on leading edges.
    assign shift_evt  = sclk_edge && (cpha_q ? leading : (!leading && !final_edge));
    assign sample_evt = sclk_edge && (cpha_q ? !leading : leading);

    assign in_range = ({1'b0, sel_q} < SS_LIMIT);

    // The transmit register always holds the next bit to go out at its
    // "first" end; which end that is depends on the shift order.
    assign tx_first   = lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
    assign tx_shifted = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    assign in_first   = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    assign in_shifted = lsb_first ? (tx_data >> 1) : (tx_data << 1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: each timed phase ends on a divider expiry; XFER ends on the final edge.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: if (div_last) state_next = S_XFER;
            S_XFER:  if (div_last && final_edge) state_next = S_HOLD;
            S_HOLD:  if (div_last) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Divider and edge counters; both rest at zero outside an active transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state == S_IDLE || state == S_FIN) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            if (sclk_edge) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    // Transaction latch, shift registers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            rx_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            if (accept) begin
                sel_q  <= ss_sel;
                cpol_q <= cpol;
                cpha_q <= cpha;
                lsb_q  <= lsb_first;
                rx_sr  <= '0;
                if (!cpha) begin
                    mosi_q <= in_first;
                    tx_sr  <= in_shifted;
                end else begin
                    tx_sr  <= tx_data;
                end
            end

            if (accept) begin
                sclk_q <= cpol;
            end else if (sclk_edge) begin
                sclk_q <= ~sclk_q;
            end else if (state == S_HOLD || state == S_IDLE) begin
                sclk_q <= cpol_q;
            end

            if (shift_evt) begin
                mosi_q <= tx_first;
                tx_sr  <= tx_shifted;
            end

            if (sample_evt) begin
                rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
            end

            if (state == S_HOLD && div_last) begin
                rx_q <= rx_sr;
            end
        end
    end

    // Slave selects: one line low for the whole active window, none when the index is out of range.
    always_comb begin
        ss_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (busy && in_range && (sel_q == SS_W'(i))) begin
                ss_n[i] = 1'b0;
            end
        end
    end

    assign busy    = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
    assign done    = (state == S_FIN);
    assign sel_err = (state == S_FIN) && !in_range;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule
